rot_btn_ctl: RTL
================

Name: rot_btn_ctl

Overview:
- Pushbutton front end for the rotating-square display path.
- Takes two raw, asynchronous, bouncing board pushbuttons; synchronises and debounces each one.
- Converts clean presses into the level controls `en` (run/pause) and `cw` (direction), which feed the `en`/`cw` inputs of the rotating-square pattern generator.
- Also emits one-cycle press strobes, for status LEDs or for other consumers.

Parameters:
- DB_CYCLES, 2000000, number of consecutive stable clocks required to accept a level change (20 ms at 100 MHz); legal range >= 2.
- EN_INIT, 1'b0, value of `en` after reset.
- CW_INIT, 1'b1, value of `cw` after reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- btn_en_raw  input  1  raw run/pause pushbutton, active-high, asynchronous, may bounce
- btn_dir_raw  input  1  raw direction pushbutton, active-high, asynchronous, may bounce
- en  output  1  run enable level; toggles on each accepted press of btn_en_raw
- cw  output  1  direction level (1 = clockwise); toggles on each accepted press of btn_dir_raw
- en_press  output  1  one-cycle strobe on each accepted press of btn_en_raw
- dir_press  output  1  one-cycle strobe on each accepted press of btn_dir_raw

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low (`clk`, `rst_n`).
  - While rst_n = 0 at a clk edge: both 2-flop synchronisers clear to 0, both FSMs go to ZERO, counters clear to 0.
  - Outputs after that edge: en = EN_INIT, cw = CW_INIT, en_press = 0, dir_press = 0.
  - Reset asserted mid-debounce abandons the pending change; no strobe is produced.
- Synchroniser: each raw input passes through 2 flops (s1 then s2). Only s2 is used by the logic.
- Debounce FSM: two identical independent instances, each with a counter of width clog2(DB_CYCLES).
  - ZERO: if s2 = 1, go to WAIT1 with cnt <= 0.
  - WAIT1:
    - if s2 = 0, go to ZERO with cnt <= 0;
    - else if cnt = DB_CYCLES-1, go to ONE and assert the strobe for that one cycle;
    - else cnt <= cnt+1.
  - ONE: if s2 = 0, go to WAIT0 with cnt <= 0.
  - WAIT0:
    - if s2 = 1, go to ONE;
    - else if cnt = DB_CYCLES-1, go to ZERO;
    - else cnt <= cnt+1.
  - Release is debounced exactly like press. It produces no strobe.
- Latency:
  - Raw input goes high and stays stable from clock edge e0.
  - Strobe is registered high in the cycle after edge e0 + DB_CYCLES + 2, i.e. DB_CYCLES+3 edges in total.
  - The strobe is high for exactly 1 cycle.
  - The toggle of `en`/`cw` is registered on the same edge as the strobe rises.
- Bounce: any return of s2 to the old level before the count completes restarts qualification from ZERO (or ONE). No strobe, no toggle.
- Held button: exactly one strobe per press, regardless of hold length. A new press is accepted only after a debounced release (back in ZERO).
- Simultaneous presses: both channels are fully independent. Both strobes may assert in the same cycle, and `en` and `cw` toggle on the same edge.
- Outputs are all registered; there is no combinational path from any input to any output.

Test Plan:
- Reset and defaults (DB_CYCLES=4): hold rst_n=0 for 3 clocks, then release → en=0, cw=1, en_press=dir_press=0 at the first edge with rst_n=1 and after; they stay so with buttons idle for 50 clocks.
- Clean press (DB_CYCLES=4): btn_en_raw 0→1 before edge e0, held 20 clocks → en_press high only in the cycle after edge e0+6; en goes 0→1 at that edge; cw unchanged. Release held 20 clocks → no strobe, en stays 1.
- Bounce rejection (DB_CYCLES=4): btn_dir_raw pattern 1,1,0,1,1,1,0 (one value per clock), then 0 for 20 clocks → dir_press never asserts, cw stays 1. Then a stable 1 for 10 clocks → exactly one dir_press, cw goes 1→0.
- Held button plus re-press (DB_CYCLES=4):
  - btn_en_raw high for 100 clocks → exactly one en_press.
  - Low for 3 clocks, then high again → no new strobe (release was not qualified).
  - Low for 10 clocks, then high for 10 → second strobe, en returns to 0.
- Simultaneous (DB_CYCLES=4): both raw inputs rise on the same edge and are held → en_press and dir_press assert in the same cycle; en=1 and cw=0 on the same edge.
- Reset mid-debounce (DB_CYCLES=8): btn_en_raw high; rst_n=0 for 1 clock at edge e0+5, with the input still held high → no strobe from the aborted count. After reset, en_press asserts DB_CYCLES+3 edges after the first post-reset edge, and en=1.

Source files
------------

// File: rtl/rot_btn_ctl_if.sv
// rtl/rot_btn_ctl_if.sv - button inputs and run/direction control outputs of rot_btn_ctl
interface rot_btn_ctl_if;
   logic btn_en_raw;
   logic btn_dir_raw;
   logic en;
   logic cw;
   logic en_press;
   logic dir_press;

   modport master (
      output btn_en_raw,
      output btn_dir_raw,
      input  en,
      input  cw,
      input  en_press,
      input  dir_press
   );

   modport slave (
      input  btn_en_raw,
      input  btn_dir_raw,
      output en,
      output cw,
      output en_press,
      output dir_press
   );
endinterface

// File: rtl/rot_btn_ctl.sv
// rtl/rot_btn_ctl.sv - synchronise and debounce two pushbuttons into run/direction levels and press strobes
// Channel 0 is the run/pause button (en), channel 1 the direction button (cw).
module rot_btn_ctl #(
   parameter int unsigned DB_CYCLES = 2000000,
   parameter logic        EN_INIT   = 1'b0,
   parameter logic        CW_INIT   = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   rot_btn_ctl_if.slave bus
);
   localparam int unsigned      CNT_W    = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
   localparam logic [1:0]       LVL_INIT = {CW_INIT, EN_INIT};

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   logic [1:0]       w_raw;
   logic [1:0]       r_s1;
   logic [1:0]       r_s2;
   logic [1:0]       r_press;
   logic [1:0]       r_lvl;
   state_t           r_state [2];
   logic [CNT_W-1:0] r_cnt   [2];

   assign w_raw = {bus.btn_dir_raw, bus.btn_en_raw};

   always_ff @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst_n) begin
            r_s1[g]    <= 1'b0;
            r_s2[g]    <= 1'b0;
            r_state[g] <= ZERO;
            r_cnt[g]   <= '0;
            r_press[g] <= 1'b0;
            r_lvl[g]   <= LVL_INIT[g];
         end else begin
            r_s1[g]    <= w_raw[g];
            r_s2[g]    <= r_s1[g];
            r_press[g] <= 1'b0;
            case (r_state[g])
               ZERO: begin
                  if (r_s2[g]) begin
                     r_state[g] <= WAIT1;
                     r_cnt[g]   <= '0;
                  end
               end
               WAIT1: begin
                  if (!r_s2[g]) begin
                     r_state[g] <= ZERO;
                     r_cnt[g]   <= '0;
                  end else if (r_cnt[g] == CNT_MAX) begin
                     // Accepted press: strobe and level toggle land on the same edge.
                     r_state[g] <= ONE;
                     r_press[g] <= 1'b1;
                     r_lvl[g]   <= ~r_lvl[g];
                  end else begin
                     r_cnt[g] <= r_cnt[g] + CNT_W'(1);
                  end
               end
               ONE: begin
                  if (!r_s2[g]) begin
                     r_state[g] <= WAIT0;
                     r_cnt[g]   <= '0;
                  end
               end
               WAIT0: begin
                  if (r_s2[g]) begin
                     r_state[g] <= ONE;
                  end else if (r_cnt[g] == CNT_MAX) begin
                     r_state[g] <= ZERO;
                  end else begin
                     r_cnt[g] <= r_cnt[g] + CNT_W'(1);
                  end
               end
               default: begin
                  r_state[g] <= ZERO;
                  r_cnt[g]   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.en        = r_lvl[0];
   assign bus.cw        = r_lvl[1];
   assign bus.en_press  = r_press[0];
   assign bus.dir_press = r_press[1];
endmodule
